ram_sp_fifo_ctrl: RTL and testbench

//  FIFO controller that drives the shared-address port of single-port sync-read RAM ram_sp_sr_sv (addr/q/rd_q/we/oe).

---
 rtl/ram_fifo_pkg.sv | 23 ++
 rtl/fifo_skid2.sv | 81 ++++++++
 rtl/ram_sp_sr_sv.sv | 34 +++
 rtl/ram_sp_fifo_ctrl.sv | 140 ++++++++++++++
 tb/tb_ram_sp_fifo_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : ram_fifo_pkg                                               |
// | Shared types for the single-port RAM FIFO controller.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ram_fifo_pkg;

  // Which side won the most recent RAM slot; drives round-robin fairness.
  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  // Operation placed on the shared RAM port in the current cycle.
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } ram_op_t;

endpackage
`default_nettype wire

// File: rtl/fifo_skid2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_skid2                                                 |
// | Two-entry output register buffer; head entry drives out_data.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_skid2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic [DATA_W-1:0] head_nxt;
  logic [DATA_W-1:0] tail_nxt;
  logic [1:0]        cnt_nxt;
  logic              push;
  logic              pop;

  assign out_valid = (cnt != 2'd0);
  assign out_data  = head;
  assign push      = in_valid;
  assign pop       = out_valid && out_ready;

  // Next head/tail/count; a simultaneous push and pop keeps the count and
  // moves the queue forward by one so nothing is lost or duplicated.
  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    cnt_nxt  = cnt;
    case ({push, pop})
      2'b10: begin
        if (cnt == 2'd0) begin
          head_nxt = in_data;
          cnt_nxt  = 2'd1;
        end else if (cnt == 2'd1) begin
          tail_nxt = in_data;
          cnt_nxt  = 2'd2;
        end
        // cnt == 2 with no pop cannot occur: the controller never has more
        // than two words outstanding.
      end
      2'b01: begin
        head_nxt = tail;
        cnt_nxt  = cnt - 2'd1;
      end
      2'b11: begin
        if (cnt == 2'd1) begin
          head_nxt = in_data;
        end else begin
          head_nxt = tail;
          tail_nxt = in_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_sp_sr_sv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram_sp_sr_sv                                               |
// | Single-port RAM with shared address and synchronous read.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ram_sp_sr_sv #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] rd_q,
  input  logic              we,
  input  logic              oe
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write on we; read data appears on rd_q the cycle after oe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= q;
    end
    if (oe) begin
      rd_q <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_sp_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram_sp_fifo_ctrl                                           |
// | FIFO controller over a single-port sync-read RAM: arbitrates one     |
// | write or read per cycle and returns data through a 2-entry buffer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ram_sp_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_oe,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W+1:0] level,
  output logic              full,
  output logic              empty
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              inflight;
  grant_t            last_grant;

  logic [ADDR_W-1:0] wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr_nxt;
  logic [ADDR_W:0]   ram_cnt_nxt;
  logic              inflight_nxt;
  grant_t            last_grant_nxt;

  ram_op_t           op;
  logic [1:0]        skid_cnt;
  logic [1:0]        pending;
  logic              wr_elig;
  logic              rd_elig;
  logic              wr_req;

  // Words already committed to the output side: buffered plus in flight.
  assign pending = skid_cnt + {1'b0, inflight};
  assign wr_elig = (ram_cnt < CNT_FULL);
  assign rd_elig = (ram_cnt != '0) && (pending < 2'd2);
  assign wr_req  = wr_valid && wr_elig;

  // wr_ready must not look at wr_valid, so it is derived from eligibility
  // and the fairness state only.
  assign wr_ready = wr_elig && !(rd_elig && (last_grant == GRANT_WRITE));

  // Arbiter: alternate under contention, otherwise serve whoever asks.
  always_comb begin
    op = OP_NONE;
    if (wr_req && rd_elig) begin
      op = (last_grant == GRANT_WRITE) ? OP_READ : OP_WRITE;
    end else if (wr_req) begin
      op = OP_WRITE;
    end else if (rd_elig) begin
      op = OP_READ;
    end
  end

  // Pointer, occupancy and fairness updates for the chosen operation.
  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    ram_cnt_nxt    = ram_cnt;
    last_grant_nxt = last_grant;
    inflight_nxt   = 1'b0;
    case (op)
      OP_WRITE: begin
        wr_ptr_nxt     = wr_ptr + 1'b1;
        ram_cnt_nxt    = ram_cnt + 1'b1;
        last_grant_nxt = GRANT_WRITE;
      end
      OP_READ: begin
        rd_ptr_nxt     = rd_ptr + 1'b1;
        ram_cnt_nxt    = ram_cnt - 1'b1;
        last_grant_nxt = GRANT_READ;
        inflight_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  // Controller state; reset drops any read still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      inflight   <= 1'b0;
      last_grant <= GRANT_READ;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      ram_cnt    <= ram_cnt_nxt;
      inflight   <= inflight_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // RAM port mux; strobes are forced low while reset is held.
  assign ram_we    = reset && (op == OP_WRITE);
  assign ram_oe    = reset && (op == OP_READ);
  assign ram_addr  = (op == OP_READ) ? rd_ptr : wr_ptr;
  assign ram_wdata = wr_data;

  fifo_skid2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight),
    .in_data   (ram_rdata),
    .out_ready (rd_ready),
    .out_valid (rd_valid),
    .out_data  (rd_data),
    .cnt       (skid_cnt)
  );

  assign level = (ADDR_W+2)'(ram_cnt) + (ADDR_W+2)'(skid_cnt) + (ADDR_W+2)'(inflight);
  assign full  = (ram_cnt == CNT_FULL);
  assign empty = (level == '0);

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ram_sp_fifo_ctrl                                        |
// | Self-checking bench: FIFO controller plus single-port RAM.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ram_sp_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_oe;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W+1:0] level;
  logic              full;
  logic              empty;

  ram_sp_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_rdata(ram_rdata),
    .level(level), .full(full), .empty(empty)
  );

  ram_sp_sr_sv #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk), .addr(ram_addr), .q(ram_wdata), .rd_q(ram_rdata),
    .we(ram_we), .oe(ram_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       ev;
    logic [7:0] ed;
    logic [9:0] elvl;
    logic       ewr;
    logic       ewe;
    logic       eoe;
    logic       eempty;
  } vec_t;

  vec_t       vt [12];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];
  int         issued = 0;
  int         pops = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic       s_acc, s_pop, s_oe, s_we, s_full;
  logic [7:0] s_pop_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_clear();
    sb.delete();
    issued    = 0;
    pops      = 0;
    hold_prev = 1'b0;
  endtask

  // Called at the negedge: scoreboard, hold-stability and outstanding-read checks.
  task automatic sample();
    s_acc      = wr_valid && wr_ready;
    s_pop      = rd_valid && rd_ready;
    s_oe       = ram_oe;
    s_we       = ram_we;
    s_full     = full;
    s_pop_data = rd_data;
    if (hold_prev) begin
      check("hold_valid", 64'(rd_valid), 64'd1);
      check("hold_data", 64'(rd_data), 64'(data_prev));
    end
    if (ram_oe) issued++;
    if (s_acc) sb.push_back(wr_data);
    if (s_pop) begin
      pops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_order: got %0h expected nothing", rd_data);
      end else begin
        check("pop_order", 64'(rd_data), 64'(sb.pop_front()));
      end
    end
    check("outstanding_le2", 64'((issued - pops) <= 2), 64'd1);
    hold_prev = rd_valid && !rd_ready;
    data_prev = rd_data;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         p0;
    int         n;
    logic       done;
    logic       prev_oe;
    logic [7:0] k;
    logic [22:0] got, exp;

    vt[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 10'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hC3, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset: strobes stay low even with a write presented.
    reset    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("we_in_reset", 64'(ram_we), 64'd0);
    check("oe_in_reset", 64'(ram_oe), 64'd0);
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) cycle();
    @(negedge clk);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_we_oe", 64'({ram_we, ram_oe}), 64'd0);
    @(posedge clk);
    #1;

    // Table: single word latency, then contention and backpressure by hand.
    for (int i = 0; i < 12; i++) begin
      wr_valid = vt[i].wv;
      wr_data  = vt[i].wd;
      rd_ready = vt[i].rr;
      @(negedge clk);
      got = {rd_valid, rd_valid ? rd_data : 8'h00, level, wr_ready, ram_we, ram_oe, empty};
      exp = {vt[i].ev, vt[i].ed, vt[i].elvl, vt[i].ewr, vt[i].ewe, vt[i].eoe, vt[i].eempty};
      check($sformatf("vec%0d", i), 64'(got), 64'(exp));
      sample();
      @(posedge clk);
      #1;
    end

    // Fill until full with rd_ready low.
    wr_valid = 1'b1;
    rd_ready = 1'b0;
    n        = 0;
    done     = 1'b0;
    for (int c = 0; c < 700 && !done; c++) begin
      wr_data = 8'(n * 2);
      cycle();
      if (s_acc) n++;
      if (s_full) done = 1'b1;
    end
    check("fill_timeout", 64'(done), 64'd1);
    wr_valid = 1'b0;
    repeat (4) cycle();
    @(negedge clk);
    check("fill_full", 64'(full), 64'd1);
    check("fill_level", 64'(level), 64'd258);
    check("fill_wr_ready", 64'(wr_ready), 64'd0);
    check("fill_accepts", 64'(n), 64'd258);
    @(posedge clk);
    #1;

    // Drain everything; scoreboard checks 0x00,0x02,... order.
    rd_ready = 1'b1;
    p0 = pops;
    for (int c = 0; c < 1000 && (pops - p0) < 258; c++) cycle();
    check("drain_count", 64'(pops - p0), 64'd258);
    @(negedge clk);
    check("drain_empty", 64'(empty), 64'd1);
    @(posedge clk);
    #1;

    // Contention: prefill, then write and read continuously.
    wr_valid = 1'b1;
    rd_ready = 1'b0;
    k = 8'h40;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      wr_data = k;
      cycle();
      if (s_acc) begin n++; k++; end
    end
    rd_ready = 1'b1;
    p0 = pops;
    prev_oe = 1'b0;
    for (int c = 0; c < 400 && (pops - p0) < 100; c++) begin
      wr_data = k;
      cycle();
      if (s_acc) k++;
      if (c >= 4) begin
        check("cont_one_op", 64'(s_we ^ s_oe), 64'd1);
        check("cont_alternate", 64'(s_oe != prev_oe), 64'd1);
      end
      prev_oe = s_oe;
    end
    check("cont_count", 64'(pops - p0), 64'd100);
    wr_valid = 1'b0;
    for (int c = 0; c < 100 && !(empty && sb.size() == 0); c++) cycle();
    check("cont_drained", 64'(sb.size()), 64'd0);

    // Backpressure: random valid/ready.
    for (int c = 0; c < 300; c++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = 8'($urandom);
      rd_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 1000 && !(empty && sb.size() == 0); c++) cycle();
    check("bp_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check("bp_empty", 64'(empty), 64'd1);
    @(posedge clk);
    #1;

    // Stream 300 words through (pointers wrap), then reset with a read in flight.
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    p0 = pops;
    for (int c = 0; c < 1500 && (pops - p0) < 300; c++) begin
      wr_data = k;
      cycle();
      if (s_acc) k++;
    end
    check("wrap_count", 64'(pops - p0), 64'd300);
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      wr_data = k;
      cycle();
      if (s_acc) k++;
      if (s_oe) done = 1'b1;
    end
    check("inflight_seen", 64'(done), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_rd_data", 64'(rd_data), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_empty_full", 64'({empty, full}), 64'd2);
    check("mid_rst_we_oe", 64'({ram_we, ram_oe}), 64'd0);
    sb_clear();
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h11;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      cycle();
      if (s_acc) done = 1'b1;
    end
    wr_valid = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      cycle();
      if (s_pop) begin
        done = 1'b1;
        check("first_after_reset", 64'(s_pop_data), 64'h11);
      end
    end
    check("first_after_reset_seen", 64'(done), 64'd1);
    repeat (3) cycle();
    @(negedge clk);
    check("final_empty", 64'(empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
